// File: rtl/full_adder32.sv
// rtl/full_adder32.sv - registered 32-bit adder built from eight rippled 4-bit carry-lookahead groups
module full_adder32_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every in-group carry is a flat sum of products of cin, so depth stays constant.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule

module full_adder32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [8:0]  group_carry;
    logic [31:0] sum_next;

    assign group_carry[0] = cin;

    // Carries ripple group to group; cin -> cout is the critical path.
    for (genvar gi = 0; gi < 8; gi++) begin : g_group
        full_adder32_cla4 u_cla4 (
            .a    (a[gi*4 +: 4]),
            .b    (b[gi*4 +: 4]),
            .cin  (group_carry[gi]),
            .sum  (sum_next[gi*4 +: 4]),
            .cout (group_carry[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= 32'h0000_0000;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= group_carry[8];
        end
    end

endmodule

// File: tb/tb_full_adder32.sv
// tb/tb_full_adder32.sv - vector table plus random scoreboard bench for full_adder32
module tb_full_adder32;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        rst;
        logic [31:0] sum;
        logic        cout;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a   = 32'h0;
    logic [31:0] b   = 32'h0;
    logic        cin = 1'b0;
    logic [31:0] sum;
    logic        cout;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t sb[$];
    vec_t tbl[13];

    full_adder32 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check_pending();
        vec_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if ({cout, sum} !== {e.cout, e.sum}) begin
                n_bad++;
                $display("FAIL %s: got cout=%b sum=%h, expected cout=%b sum=%h",
                         e.name, cout, sum, e.cout, e.sum);
            end
        end
    endtask

    task automatic cycle(input vec_t v);
        @(negedge clk);
        check_pending();
        a   = v.a;
        b   = v.b;
        cin = v.cin;
        rst = v.rst;
        sb.push_back(v);
    endtask

    function automatic vec_t mk(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                                input logic vr, input logic [31:0] vs, input logic vco,
                                input string nm);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.rst = vr; v.sum = vs; v.cout = vco; v.name = nm;
        return v;
    endfunction

    initial begin
        vec_t        v;
        logic [32:0] full;

        tbl[0]  = mk(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0, "zero");
        tbl[1]  = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, "zero_cin");
        tbl[2]  = mk(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, "chain_full");
        tbl[3]  = mk(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, "chain_31");
        tbl[4]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, "max_cin1");
        tbl[5]  = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b1, "max_cin0");
        tbl[6]  = mk(32'h0000_000F, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0010, 1'b0, "group0_edge");
        tbl[7]  = mk(32'h0FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h1000_0000, 1'b0, "group6_edge");
        tbl[8]  = mk(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, "group1_edge");
        tbl[9]  = mk(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, "mixed");
        tbl[10] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, "msb_carry");
        tbl[11] = mk(32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 1'b0, 32'h0000_0000, 1'b1, "propagate_all");
        tbl[12] = mk(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, "propagate_nocin");

        // Reset held two cycles with operands that would otherwise carry out.
        cycle(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0, 1'b0, "reset_1"));
        cycle(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0, 1'b0, "reset_2"));
        cycle(mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, "reset_release"));

        for (int i = 0; i < 13; i++) cycle(tbl[i]);

        // Reset arriving with fresh operands wins, then results resume.
        cycle(mk(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 32'h0000_0003, 1'b0, "pre_midreset"));
        cycle(mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0000_0000, 1'b0, "midreset"));
        cycle(mk(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0031, 1'b0, "post_midreset"));

        for (int i = 0; i < 1000; i++) begin
            v.a    = $urandom;
            v.b    = $urandom;
            v.cin  = 1'($urandom_range(0, 1));
            v.rst  = 1'b0;
            full   = {1'b0, v.a} + {1'b0, v.b} + {32'h0, v.cin};
            v.sum  = full[31:0];
            v.cout = full[32];
            v.name = $sformatf("rand_%0d", i);
            cycle(v);
        end

        @(negedge clk);
        check_pending();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
